// File: rtl/clk_ctrl_pkg.sv
// rtl/clk_ctrl_pkg.sv - shared FSM encoding, default timing constants and counter helper
//
// Contents:
//   state_t            controller FSM states
//   DEF_SETTLE_CYCLES  default select settle time in i_clk cycles
//   DEF_HB_EDGES       default heartbeat edges needed to confirm the target clock
//   DEF_HB_TIMEOUT     default i_clk cycles allowed in CHECK
//   cnt_t / sat_inc    16-bit counter type and saturating increment
package clk_ctrl_pkg;

  localparam int unsigned DEF_SETTLE_CYCLES = 16;
  localparam int unsigned DEF_HB_EDGES      = 4;
  localparam int unsigned DEF_HB_TIMEOUT    = 64;
  localparam int unsigned CNT_W             = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SWITCH = 3'd1,
    ST_CHECK  = 3'd2,
    ST_REVERT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/hb_sync.sv
// rtl/hb_sync.sv - heartbeat synchronizer with toggle edge detect
//
// Ports:
//   i_clk    control clock
//   i_reset  synchronous active-high reset
//   i_hb     heartbeat toggle from a foreign clock domain
//   o_edge   one-cycle pulse for every heartbeat transition (rise or fall)
module hb_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_hb,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  // r_sync1/r_sync2 resolve metastability; r_sync3 holds the previous
  // settled value so any change of level shows up as one pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_hb;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign o_edge = r_sync2 ^ r_sync3;

endmodule

// File: rtl/clk_sel_ctrl.sv
// rtl/clk_sel_ctrl.sv - glitch-free clock switch select controller with heartbeat check and revert
//
// Parameters:
//   SETTLE_CYCLES  i_clk cycles o_sel is held before checking (also revert hold time)
//   HB_EDGES       target heartbeat edges that confirm the new clock runs
//   HB_TIMEOUT     i_clk cycles allowed in CHECK before the switch fails
// Ports:
//   i_clk, i_reset            control clock, synchronous active-high reset
//   i_req_valid, i_req_sel    switch request (sel 0 = clock A, 1 = clock B)
//   o_req_ready               request accepted when i_req_valid && o_req_ready
//   o_sel                     select line to the clock switch
//   i_hb_a, i_hb_b            heartbeat toggles from clock A / clock B domains
//   o_busy                    high whenever the controller is not idle
//   o_done, o_err             single-cycle completion / failure pulses
module clk_sel_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned HB_EDGES      = DEF_HB_EDGES,
  parameter int unsigned HB_TIMEOUT    = DEF_HB_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req_valid,
  input  logic i_req_sel,
  output logic o_req_ready,
  output logic o_sel,
  input  logic i_hb_a,
  input  logic i_hb_b,
  output logic o_busy,
  output logic o_done,
  output logic o_err
);

  localparam cnt_t SETTLE_C  = cnt_t'(SETTLE_CYCLES);
  localparam cnt_t EDGES_C   = cnt_t'(HB_EDGES);
  localparam cnt_t TIMEOUT_C = cnt_t'(HB_TIMEOUT);

  state_t r_state;
  state_t w_state_nxt;

  logic r_sel;
  logic r_prev_sel;
  logic r_done;
  logic r_err;
  cnt_t r_settle_cnt;
  cnt_t r_edge_cnt;
  cnt_t r_to_cnt;

  logic w_edge_a;
  logic w_edge_b;
  logic w_tgt_edge;
  logic w_accept;
  logic w_same_sel;
  cnt_t w_settle_inc;
  cnt_t w_edge_inc;
  cnt_t w_to_inc;
  logic w_settle_done;
  logic w_hb_ok;
  logic w_to_hit;

  hb_sync u_hb_a (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_hb    (i_hb_a),
    .o_edge  (w_edge_a)
  );

  hb_sync u_hb_b (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_hb    (i_hb_b),
    .o_edge  (w_edge_b)
  );

  // Only the heartbeat of the clock currently selected is evidence that it runs.
  assign w_tgt_edge = r_sel ? w_edge_b : w_edge_a;
  assign w_accept   = i_req_valid & o_req_ready;
  assign w_same_sel = (i_req_sel == r_sel);

  // Conditions look at the incremented value so each phase lasts exactly
  // its configured number of cycles and exits on the cycle it completes.
  assign w_settle_inc  = sat_inc(r_settle_cnt);
  assign w_edge_inc    = w_tgt_edge ? sat_inc(r_edge_cnt) : r_edge_cnt;
  assign w_to_inc      = sat_inc(r_to_cnt);
  assign w_settle_done = (w_settle_inc >= SETTLE_C);
  assign w_hb_ok       = (w_edge_inc >= EDGES_C);
  assign w_to_hit      = (w_to_inc >= TIMEOUT_C);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_same_sel ? ST_DONE : ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        if (w_settle_done) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Success is tested first so a last-cycle confirmation beats the timeout.
        if (w_hb_ok) begin
          w_state_nxt = ST_DONE;
        end else if (w_to_hit) begin
          w_state_nxt = ST_REVERT;
        end
      end
      ST_REVERT: begin
        if (w_settle_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Select line, counters and registered pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sel        <= 1'b0;
      r_prev_sel   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_settle_cnt <= '0;
      r_edge_cnt   <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_same_sel) begin
            r_prev_sel   <= r_sel;
            r_sel        <= i_req_sel;
            r_settle_cnt <= '0;
            r_edge_cnt   <= '0;
            r_to_cnt     <= '0;
          end
        end
        ST_SWITCH: begin
          if (w_settle_done) begin
            r_settle_cnt <= '0;
            r_edge_cnt   <= '0;
            r_to_cnt     <= '0;
          end else begin
            r_settle_cnt <= w_settle_inc;
          end
        end
        ST_CHECK: begin
          r_edge_cnt <= w_edge_inc;
          r_to_cnt   <= w_to_inc;
          if (!w_hb_ok && w_to_hit) begin
            // Target never proved alive: fall back to the clock we came from.
            r_sel        <= r_prev_sel;
            r_err        <= 1'b1;
            r_settle_cnt <= '0;
          end
        end
        ST_REVERT: begin
          r_settle_cnt <= w_settle_inc;
        end
        ST_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_settle_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs; ready is masked by reset so no handshake can happen while it is held.
  always_comb begin
    o_req_ready = (r_state == ST_IDLE) && !i_reset;
    o_busy      = (r_state != ST_IDLE);
    o_sel       = r_sel;
    o_done      = r_done;
    o_err       = r_err;
  end

endmodule
